// File: rtl/pipelined_mac.sv
// Pipelined signed multiply-accumulate with valid/ready streams on both sides.
// Group sums are closed by in_last, then scaled, optionally rounded half-up and saturated.
module pipelined_mac #(
  parameter int A_WIDTH     = 16,
  parameter int B_WIDTH     = 16,
  parameter int ACC_WIDTH   = 40,
  parameter int OUT_WIDTH   = 16,
  parameter int OUT_SCALE   = 8,
  parameter int PIPE_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 arst_n_in,
  input  logic [A_WIDTH-1:0]   a_in,
  input  logic [B_WIDTH-1:0]   b_in,
  input  logic                 in_last,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 round_en,
  input  logic                 sat_en,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_sat,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int PW     = A_WIDTH + B_WIDTH;
  localparam int SW     = ACC_WIDTH + 1;
  localparam int RND_SH = (OUT_SCALE > 0) ? OUT_SCALE - 1 : 0;
  localparam logic signed [SW-1:0] RND_C = (OUT_SCALE > 0) ? (SW'(1) << RND_SH) : SW'(0);
  localparam logic signed [SW-1:0] MAX_V = {{(SW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] MIN_V = {{(SW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  logic                        stall;
  logic                        take;
  logic                        close;
  logic [PIPE_STAGES-1:0]      valid_q, valid_d;
  logic [PIPE_STAGES-1:0]      last_q, last_d;
  logic signed [PW-1:0]        prod_q [PIPE_STAGES];
  logic signed [PW-1:0]        prod_d [PIPE_STAGES];
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic signed [ACC_WIDTH-1:0] prod_ext;
  logic signed [ACC_WIDTH-1:0] sum;
  logic signed [SW-1:0]        sum_ext;
  logic signed [SW-1:0]        rnd;
  logic signed [SW-1:0]        r;
  logic [OUT_WIDTH-1:0]        out_data_q, out_data_d;
  logic                        out_sat_q, out_sat_d;
  logic                        out_valid_q, out_valid_d;

  assign stall     = out_valid_q & ~out_ready;
  assign in_ready  = ~stall;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign out_valid = out_valid_q;

  // Operand pipe: index 0 is the capture stage, the whole pipe freezes on stall.
  always_comb begin
    valid_d = valid_q;
    last_d  = last_q;
    prod_d  = prod_q;
    if (!stall) begin
      valid_d[0] = in_valid;
      last_d[0]  = in_last;
      prod_d[0]  = PW'($signed(a_in)) * PW'($signed(b_in));
      for (int i = 1; i < PIPE_STAGES; i++) begin
        valid_d[i] = valid_q[i-1];
        last_d[i]  = last_q[i-1];
        prod_d[i]  = prod_q[i-1];
      end
    end
  end

  always_comb begin
    prod_ext = ACC_WIDTH'(prod_q[PIPE_STAGES-1]);
    sum      = acc_q + prod_ext;
    take     = ~stall & valid_q[PIPE_STAGES-1];
    close    = take & last_q[PIPE_STAGES-1];

    acc_d = acc_q;
    if (close)     acc_d = '0;
    else if (take) acc_d = sum;

    // One guard bit so the rounding increment cannot overflow the sum.
    sum_ext = {sum[ACC_WIDTH-1], sum};
    rnd     = round_en ? RND_C : SW'(0);
    r       = (sum_ext + rnd) >>> OUT_SCALE;

    out_data_d = out_data_q;
    out_sat_d  = out_sat_q;
    if (close) begin
      if (sat_en && (r > MAX_V)) begin
        out_data_d = MAX_V[OUT_WIDTH-1:0];
        out_sat_d  = 1'b1;
      end else if (sat_en && (r < MIN_V)) begin
        out_data_d = MIN_V[OUT_WIDTH-1:0];
        out_sat_d  = 1'b1;
      end else begin
        out_data_d = r[OUT_WIDTH-1:0];
        out_sat_d  = 1'b0;
      end
    end

    out_valid_d = close | (out_valid_q & ~out_ready);
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      valid_q     <= '0;
      last_q      <= '0;
      for (int i = 0; i < PIPE_STAGES; i++) prod_q[i] <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      last_q      <= last_d;
      for (int i = 0; i < PIPE_STAGES; i++) prod_q[i] <= prod_d[i];
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule
